// File: rtl/ucore_stream_pkg.sv
// Shared widths and helpers for the microcoded-core stream feeder.
// The core generator uses the same defaults, so generated port widths match this block.
package ucore_stream_pkg;

  localparam int unsigned UCORE_WIDTH = 32;
  localparam int unsigned UCORE_DEPTH = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ucore_fifo_ptr.sv
// FIFO pointer: a counter with an extra MSB wrap bit, increment and load.
// Load takes priority so that a flush can snap the read side onto the write side.
module ucore_fifo_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/ucore_stream_in.sv
// Input-side feeder for the microcoded core: valid/ready stream into a small FIFO,
// head word presented level-style on core_data and consumed with a core_pop strobe.
module ucore_stream_in
  import ucore_stream_pkg::*;
#(
  parameter  int unsigned WIDTH = UCORE_WIDTH,
  parameter  int unsigned DEPTH = UCORE_DEPTH,
  localparam int unsigned PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] core_data,
  output logic             core_valid,
  input  logic             core_pop,
  input  logic             flush,
  output logic [PTR_W:0]   level,
  output logic             err_underflow,
  input  logic             clr_err
);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             underflow;

  // Flags come only from registered pointers; s_ready never depends on s_valid.
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign empty = (wr_ptr == rd_ptr);

  assign s_ready    = !full;
  assign core_valid = !empty;
  assign level      = wr_ptr - rd_ptr;
  assign core_data  = mem[rd_ptr[PTR_W-1:0]];

  assign push      = s_valid && s_ready && !flush;
  assign pop       = core_pop && core_valid && !flush;
  assign underflow = core_pop && !core_valid;

  ucore_fifo_ptr #(.W(PTR_W + 1)) u_wr_ptr (
    .clk      (clk),
    .aresetn  (aresetn),
    .inc      (push),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_ptr)
  );

  ucore_fifo_ptr #(.W(PTR_W + 1)) u_rd_ptr (
    .clk      (clk),
    .aresetn  (aresetn),
    .inc      (pop),
    .load     (flush),
    .load_val (wr_ptr),
    .ptr      (rd_ptr)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= s_data;
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      err_underflow <= 1'b0;
    end else if (underflow) begin
      err_underflow <= 1'b1;
    end else if (clr_err) begin
      err_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ucore_stream_in.sv
// Self-checking bench for ucore_stream_in: scoreboard of accepted words, per-scenario tasks.
module tb_ucore_stream_in;

  logic        clk;
  logic        aresetn;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] core_data;
  logic        core_valid;
  logic        core_pop;
  logic        flush;
  logic [2:0]  level;
  logic        err_underflow;
  logic        clr_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  ucore_stream_in #(.WIDTH(32), .DEPTH(4)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .core_data     (core_data),
    .core_valid    (core_valid),
    .core_pop      (core_pop),
    .flush         (flush),
    .level         (level),
    .err_underflow (err_underflow),
    .clr_err       (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      core_pop = 1'b1;
      checks++; if (core_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b expected 1", core_valid); end
      checks++; if (core_data !== sb[0]) begin errors++; $display("FAIL drain_data: got %h expected %h", core_data, sb[0]); end
      step();
      void'(sb.pop_front());
    end
    core_pop = 1'b0;
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", core_valid); end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_valid = 1'b0; s_data = '0; core_pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    #12;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", core_valid); end
    checks++; if (core_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", core_data); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", s_ready); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_underflow); end
    @(negedge clk);
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_first_latency();
    s_valid = 1'b1; s_data = 32'hA5A5_0001;
    sb.push_back(32'hA5A5_0001);
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL lat_before: got %b expected 0", core_valid); end
    step();
    s_valid = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL lat_level: got %0d expected 1", level); end
    checks++; if (core_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", core_valid); end
    checks++; if (core_data !== sb[0]) begin errors++; $display("FAIL lat_data: got %h expected %h", core_data, sb[0]); end
    drain();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_data = 32'(i);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b expected 1", s_ready); end
      sb.push_back(32'(i));
      step();
    end
    s_data = 32'h5;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", s_ready); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", level); end
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_hold: got %0d expected 4", level); end
    core_pop = 1'b1;
    checks++; if (core_data !== sb[0]) begin errors++; $display("FAIL full_pop_data: got %h expected %h", core_data, sb[0]); end
    step();
    void'(sb.pop_front());
    core_pop = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_level: got %0d expected 3", level); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_freed: got %b expected 1", s_ready); end
    sb.push_back(32'h5);
    step();
    s_valid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d expected 4", level); end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + 32'(i);
      sb.push_back(s_data);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 32'h102 + 32'(i); core_pop = 1'b1;
      checks++; if (core_data !== sb[0]) begin errors++; $display("FAIL b2b_data: got %h expected %h", core_data, sb[0]); end
      sb.push_back(s_data);
      step();
      void'(sb.pop_front());
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level: got %0d expected 2", level); end
    end
    s_valid = 1'b0; core_pop = 1'b0;
    drain();
  endtask

  task automatic test_underflow();
    core_pop = 1'b1;
    step();
    core_pop = 1'b0;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", err_underflow); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL uf_level: got %0d expected 0", level); end
    step();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", err_underflow); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_clr: got %b expected 0", err_underflow); end
    clr_err = 1'b1; core_pop = 1'b1;
    step();
    clr_err = 1'b0; core_pop = 1'b0;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %b expected 1", err_underflow); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    s_valid = 1'b1; s_data = 32'h33; core_pop = 1'b1;
    sb.push_back(32'h33);
    step();
    s_valid = 1'b0; core_pop = 1'b0;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_push_pop_err: got %b expected 1", err_underflow); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL uf_push_pop_level: got %0d expected 1", level); end
    drain();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 32'h10 + 32'(i);
      sb.push_back(s_data);
      step();
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL fl_pre_level: got %0d expected 3", level); end
    flush = 1'b1; s_valid = 1'b1; s_data = 32'h77;
    step();
    flush = 1'b0; s_valid = 1'b0;
    sb.delete();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL fl_level: got %0d expected 0", level); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b expected 0", core_valid); end
    step();
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL fl_no77: got %b expected 0", core_valid); end
    s_valid = 1'b1; s_data = 32'h88;
    sb.push_back(32'h88);
    step();
    s_valid = 1'b0;
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'h21 + 32'(i);
      sb.push_back(s_data);
      step();
    end
    s_valid = 1'b0;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL ar_pre_level: got %0d expected 2", level); end
    @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    sb.delete();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ar_level: got %0d expected 0", level); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", core_valid); end
    checks++; if (core_data !== 32'h0) begin errors++; $display("FAIL ar_data: got %h expected 0", core_data); end
    @(negedge clk);
    aresetn = 1'b1;
    s_valid = 1'b1; s_data = 32'h99;
    sb.push_back(32'h99);
    step();
    s_valid = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL ar_post_level: got %0d expected 1", level); end
    drain();
  endtask

  initial begin
    test_reset();
    test_first_latency();
    test_full();
    test_back_to_back();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucore_stream_in.md
Name: ucore_stream_in

Overview:
- Input-side feeder for a generated microcoded core.
- Accepts a valid/ready stream from upstream logic and buffers it in a small FIFO.
- Presents the head word on a level-style input port that the core's FSM reads directly. The core consumes the word with a one-cycle pop strobe.
- Decouples upstream timing from the core's state-by-state execution, so a program can poll core_valid and read core_data in any state.

Parameters:
- WIDTH, 32, data word width in bits; must match the hi:lo span of the core input port.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, log2(DEPTH), derived localparam; not overridable.

Ports:
- clk  input  1  global clock
- aresetn  input  1  asynchronous reset, active low
- s_valid  input  1  upstream word valid
- s_ready  output  1  block can accept a word this cycle
- s_data  input  WIDTH  upstream word
- core_data  output  WIDTH  head-of-FIFO word, read by the core
- core_valid  output  1  core_data holds an unconsumed word
- core_pop  input  1  core consumes the head word this cycle
- flush  input  1  synchronous discard of all buffered words
- level  output  PTR_W+1  number of buffered words, 0..DEPTH
- err_underflow  output  1  sticky: core_pop was seen while core_valid was low
- clr_err  input  1  synchronous clear of err_underflow

Behaviour:
- Reset is asynchronous on aresetn low. Reset values:
  - rd_ptr=0, wr_ptr=0 (each PTR_W+1 bits, MSB is the wrap bit)
  - all storage entries=0
  - level=0, core_valid=0, core_data=0, s_ready=1 (deasserted during reset is also acceptable; spec it as 1), err_underflow=0
- Assert aresetn asynchronously; release it synchronously to clk (the synchronizer is upstream of this block).
- Push = s_valid & s_ready & !flush. On push, storage[wr_ptr[PTR_W-1:0]] <= s_data and wr_ptr increments.
- Pop = core_pop & core_valid & !flush. On pop, rd_ptr increments.
- Full when pointer low bits are equal and wrap bits differ. Empty when the pointers are equal.
- Flags:
  - s_ready = !full, combinational from registered pointers; no combinational path from s_valid.
  - core_valid = !empty.
  - core_data = storage[rd_ptr[PTR_W-1:0]], muxed from registers.
- Latency: a word accepted at clock edge N appears on core_data with core_valid=1 in the cycle after edge N. There is no same-cycle pass-through.
- A pop at edge N exposes the next word, or core_valid=0, in the cycle after edge N.
- level = wr_ptr - rd_ptr, modulo 2^(PTR_W+1).
- Boundary conditions:
  - Full: s_ready=0. There is no push even if core_pop is high in the same cycle; the freed slot becomes visible the next cycle.
  - Simultaneous push and pop with 1 <= level <= DEPTH-1: both execute and level is unchanged.
  - Empty with core_pop=1: no pointer change; err_underflow <= 1 at the next edge.
  - Empty with simultaneous push and core_pop: push executes and underflow is flagged.
- Wrap-around: pointers roll over naturally with no special case; the wrap bit disambiguates full from empty.
- flush=1: rd_ptr <= wr_ptr, so the FIFO empties next cycle. flush has priority over push and pop; a word offered while flush=1 is not accepted. Storage contents are not cleared.
- err_underflow:
  - Sets on underflow and holds until clr_err.
  - If clr_err and a new underflow occur in the same cycle, set wins.
  - Unaffected by flush.
- Reset mid-operation: all buffered words are lost and the block returns to the reset state immediately.

Decomposition:
- Package ucore_stream_pkg holds:
  - a clog2 constant function
  - the default WIDTH/DEPTH localparams shared with the core generator, so generated port widths and this block agree.
- One natural sub-module, ucore_fifo_ptr:
  - PTR_W+1 bit counter with wrap bit, inc and load inputs, async reset to 0.
  - Instantiated twice: as wr_ptr (inc=push) and as rd_ptr (inc=pop, load=flush with value wr_ptr).
- Full/empty/level logic stays in the top module.

Test Plan:
- After reset, push 0xA5A5_0001 at edge 1 -> level=1, core_valid=1 and core_data=0xA5A5_0001 in the cycle after edge 1; core_valid=0 during the cycle of edge 1.
- DEPTH=4: push 0x1..0x4 back-to-back with no pop -> s_ready=0 after the 4th edge, level=4. A 5th word 0x5 held valid is not accepted until one pop. Pops then return 0x1,0x2,0x3,0x4,0x5 in order.
- Level=2, push and pop held for 10 cycles with incrementing data -> level stays 2 and popped data is strictly sequential across pointer wrap.
- Empty, pulse core_pop for 1 cycle -> err_underflow=1 from the next edge, pointers unchanged. Then clr_err=1 for 1 cycle -> err_underflow=0. clr_err held together with a new underflow -> err_underflow stays 1.
- Level=3, flush=1 with s_valid=1 and data 0x77 -> next cycle level=0, core_valid=0, and 0x77 is never delivered.
- Level=2, drive aresetn low asynchronously mid-cycle -> level=0, core_valid=0, core_data=0 immediately. After release, the first push is delivered normally.
